// File: rtl/apb_slave_if_p.sv
// APB4 slave front-end for the timer register file. Latches each transfer in
// the setup phase, inserts a programmable number of wait states, issues a
// single-cycle register strobe and reports decode/register-file errors.
module apb_slave_if_p #(
  parameter int unsigned       ADDR_W     = 12,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       WS_W       = 4,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 12'h100,
  parameter bit                ALIGN_CHK  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_psel,
  input  logic                i_penable,
  input  logic                i_pwrite,
  input  logic [ADDR_W-1:0]   i_paddr,
  input  logic [DATA_W-1:0]   i_pwdata,
  input  logic [DATA_W/8-1:0] i_pstrb,
  input  logic [WS_W-1:0]     i_wait_cfg,
  input  logic [DATA_W-1:0]   i_rdata,
  input  logic                i_error,
  output logic                o_pready,
  output logic                o_pslverr,
  output logic [DATA_W-1:0]   o_prdata,
  output logic                o_reg_ren,
  output logic                o_reg_wen,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W/8-1:0] o_byte_en,
  output logic                o_busy
);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

  state_e              r_state, w_state_d;
  logic [WS_W-1:0]     r_cnt;
  logic                r_write;
  logic                r_derr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_byte_en;
  logic                r_pready;
  logic                r_pslverr;
  logic [DATA_W-1:0]   r_prdata;

  logic w_setup;     // setup phase accepted this cycle
  logic w_complete;  // ACCESS cycle that will raise pready
  logic w_derr;      // decode error of the address on the bus
  logic w_err;       // error reported for the transfer in ACCESS

  assign w_derr = (i_paddr >= ADDR_LIMIT) || (ALIGN_CHK && (i_paddr[1:0] != 2'b00));
  // A decode error masks the register-file error input.
  assign w_err  = r_derr | (i_error & ~r_derr);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state decode; psel low in WAIT or ACCESS aborts the transfer.
  always_comb begin
    w_state_d  = r_state;
    w_setup    = 1'b0;
    w_complete = 1'b0;
    unique case (r_state)
      StIdle: begin
        // penable without a preceding setup phase is ignored.
        if (i_psel && !i_penable) begin
          w_setup   = 1'b1;
          w_state_d = (i_wait_cfg != '0) ? StWait : StAccess;
        end
      end
      StWait: begin
        if (!i_psel) begin
          w_state_d = StIdle;
        end else if (r_cnt == WS_W'(1)) begin
          w_state_d = StAccess;
        end
      end
      StAccess: begin
        if (!i_psel) begin
          w_state_d = StIdle;
        end else begin
          w_complete = 1'b1;
          w_state_d  = StResp;
        end
      end
      StResp: begin
        // Next setup phase can only arrive in the following cycle.
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Setup-phase latches, wait counter and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_derr    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_byte_en <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      if (w_setup) begin
        r_cnt     <= i_wait_cfg;
        r_write   <= i_pwrite;
        r_derr    <= w_derr;
        r_addr    <= i_paddr;
        r_wdata   <= i_pwdata;
        r_byte_en <= i_pwrite ? i_pstrb : '0;
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt - WS_W'(1);
      end
      // pready/pslverr are high only in the RESP cycle.
      r_pready  <= w_complete;
      r_pslverr <= w_complete & w_err;
      if (w_complete && !r_write) begin
        r_prdata <= w_err ? '0 : i_rdata;
      end
    end
  end

  assign o_reg_wen = (r_state == StAccess) & r_write & ~r_derr;
  assign o_reg_ren = (r_state == StAccess) & ~r_write & ~r_derr;
  assign o_busy    = (r_state != StIdle);
  assign o_pready  = r_pready;
  assign o_pslverr = r_pslverr;
  assign o_prdata  = r_prdata;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;
  assign o_byte_en = r_byte_en;

endmodule

// File: tb/tb_apb_slave_if_p.sv
// Scoreboard bench for apb_slave_if_p: stimulus pushes expected strobe and
// response events; a negedge monitor pops and compares them as they appear.
module tb_apb_slave_if_p;

  typedef struct {
    int          cyc;
    bit          wen;
    bit          ren;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } strb_t;

  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] rdata;
  } resp_t;

  logic        clk, rst_n, psel, penable, pwrite, error;
  logic [11:0] paddr;
  logic [31:0] pwdata, rdata;
  logic [3:0]  pstrb, wait_cfg;
  logic        pready, pslverr, reg_ren, reg_wen, busy;
  logic [31:0] prdata, wdata;
  logic [11:0] addr;
  logic [3:0]  byte_en;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  strb_t strb_q[$];
  resp_t resp_q[$];
  strb_t mon_se;
  resp_t mon_re;

  apb_slave_if_p #(
    .ADDR_W    (12),
    .DATA_W    (32),
    .WS_W      (4),
    .ADDR_LIMIT(12'h100),
    .ALIGN_CHK (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_psel    (psel),
    .i_penable (penable),
    .i_pwrite  (pwrite),
    .i_paddr   (paddr),
    .i_pwdata  (pwdata),
    .i_pstrb   (pstrb),
    .i_wait_cfg(wait_cfg),
    .i_rdata   (rdata),
    .i_error   (error),
    .o_pready  (pready),
    .o_pslverr (pslverr),
    .o_prdata  (prdata),
    .o_reg_ren (reg_ren),
    .o_reg_wen (reg_wen),
    .o_addr    (addr),
    .o_wdata   (wdata),
    .o_byte_en (byte_en),
    .o_busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Monitor: compare every strobe and every pready against the queues.
  always @(negedge clk) begin
    while (strb_q.size() != 0 && strb_q[0].cyc < cyc) begin
      mon_se = strb_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL strobe_missing: got none, expected at cyc %0d addr %h", mon_se.cyc,
               mon_se.addr);
    end
    while (resp_q.size() != 0 && resp_q[0].cyc < cyc) begin
      mon_re = resp_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL pready_missing: got none, expected at cyc %0d", mon_re.cyc);
    end
    if (reg_wen || reg_ren) begin
      n_checks++;
      if (strb_q.size() == 0) begin
        n_errors++;
        $display("FAIL strobe_unexpected: got wen %0b ren %0b addr %h at cyc %0d, expected none",
                 reg_wen, reg_ren, addr, cyc);
      end else begin
        mon_se = strb_q.pop_front();
        if (mon_se.cyc != cyc || mon_se.wen != reg_wen || mon_se.ren != reg_ren ||
            mon_se.addr != addr || mon_se.wdata != wdata || mon_se.be != byte_en) begin
          n_errors++;
          $display({"FAIL strobe: got cyc %0d wen %0b ren %0b addr %h wdata %h be %h, ",
                    "expected cyc %0d wen %0b ren %0b addr %h wdata %h be %h"},
                   cyc, reg_wen, reg_ren, addr, wdata, byte_en,
                   mon_se.cyc, mon_se.wen, mon_se.ren, mon_se.addr, mon_se.wdata, mon_se.be);
        end
      end
    end
    if (pready) begin
      n_checks++;
      if (resp_q.size() == 0) begin
        n_errors++;
        $display("FAIL pready_unexpected: got pready at cyc %0d, expected none", cyc);
      end else begin
        mon_re = resp_q.pop_front();
        if (mon_re.cyc != cyc || mon_re.err != pslverr || mon_re.rdata != prdata) begin
          n_errors++;
          $display("FAIL response: got cyc %0d pslverr %0b prdata %h, expected cyc %0d pslverr %0b prdata %h",
                   cyc, pslverr, prdata, mon_re.cyc, mon_re.err, mon_re.rdata);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pready"},  32'(pready),  32'h0);
    chk({tag, "_pslverr"}, 32'(pslverr), 32'h0);
    chk({tag, "_prdata"},  prdata,       32'h0);
    chk({tag, "_reg_ren"}, 32'(reg_ren), 32'h0);
    chk({tag, "_reg_wen"}, 32'(reg_wen), 32'h0);
    chk({tag, "_addr"},    32'(addr),    32'h0);
    chk({tag, "_wdata"},   wdata,        32'h0);
    chk({tag, "_byte_en"}, 32'(byte_en), 32'h0);
    chk({tag, "_busy"},    32'(busy),    32'h0);
  endtask

  // Full transfer; returns in the pready cycle so the next call is back-to-back.
  task automatic apb_xfer(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input logic [3:0] ws, input logic [31:0] rd,
                          input bit er, input bit exp_strb, input bit exp_err,
                          input logic [31:0] exp_prdata);
    int    t0;
    bit    got;
    strb_t se;
    resp_t re;
    @(posedge clk);
    #1;
    t0 = cyc;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    wait_cfg = ws; rdata = rd; error = er;
    if (exp_strb) begin
      se.cyc = t0 + 1 + int'(ws); se.wen = wr; se.ren = !wr; se.addr = a; se.wdata = wd;
      se.be = wr ? st : 4'h0;
      strb_q.push_back(se);
    end
    re.cyc = t0 + 2 + int'(ws); re.err = exp_err; re.rdata = exp_prdata;
    resp_q.push_back(re);
    @(posedge clk);
    #1;
    penable = 1'b1;
    wait_cfg = ~ws;  // must not affect the transfer in flight
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL pready_timeout: got no pready, expected at cyc %0d", re.cyc);
    end
  endtask

  // Transfer dropped by psel=0 in cycle T0+k.
  task automatic apb_abort(input logic [11:0] a, input logic [3:0] ws, input int k,
                           input bit exp_strb);
    int    t0;
    strb_t se;
    @(posedge clk);
    #1;
    t0 = cyc;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a; pstrb = 4'hF; wait_cfg = ws;
    rdata = 32'h0; error = 1'b0;
    if (exp_strb) begin
      se.cyc = t0 + k; se.wen = 1'b0; se.ren = 1'b1; se.addr = a; se.wdata = pwdata;
      se.be = 4'h0;
      strb_q.push_back(se);
    end
    @(posedge clk);
    #1;
    penable = 1'b1;
    for (int i = 1; i < k; i++) begin
      @(posedge clk);
      #1;
    end
    psel = 1'b0;
    penable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    pstrb = '0; wait_cfg = '0; rdata = '0; error = 1'b0;
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    //       wr    addr     wdata         strb  ws    rdata         err  strb err prdata
    apb_xfer(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 4'd0, 32'hAAAA5555, 1'b0, 1, 0, 32'h0);
    apb_xfer(1'b0, 12'h020, 32'h0,        4'hF, 4'd3, 32'h12345678, 1'b0, 1, 0, 32'h12345678);
    apb_xfer(1'b0, 12'h100, 32'h0,        4'h0, 4'd0, 32'hFFFFFFFF, 1'b0, 0, 1, 32'h0);
    apb_xfer(1'b0, 12'h012, 32'h0,        4'h0, 4'd1, 32'hCAFEF00D, 1'b1, 0, 1, 32'h0);
    apb_xfer(1'b1, 12'h004, 32'h11223344, 4'h3, 4'd2, 32'h0,        1'b1, 1, 1, 32'h0);
    @(negedge clk);
    chk("pslverr_after_resp", 32'(pslverr), 32'h0);
    chk("pready_after_resp",  32'(pready),  32'h0);
    apb_xfer(1'b0, 12'h0FC, 32'h0,        4'h0, 4'd15, 32'h0BADCAFE, 1'b0, 1, 0, 32'h0BADCAFE);
    apb_xfer(1'b1, 12'h018, 32'hCAFEF00D, 4'h6, 4'd1, 32'h0,        1'b0, 1, 0, 32'h0BADCAFE);
    apb_xfer(1'b0, 12'h008, 32'h0,        4'h0, 4'd0, 32'h55AA55AA, 1'b1, 1, 1, 32'h0);

    // Abort in WAIT, then a normal write.
    apb_abort(12'h010, 4'd5, 2, 1'b0);
    apb_xfer(1'b1, 12'h008, 32'h000000FF, 4'h1, 4'd0, 32'h0, 1'b0, 1, 0, 32'h0);
    // Abort in ACCESS: strobe fires, no pready.
    apb_abort(12'h010, 4'd1, 2, 1'b1);
    apb_xfer(1'b0, 12'h00C, 32'h0,        4'h0, 4'd0, 32'hA5A5A5A5, 1'b0, 1, 0, 32'hA5A5A5A5);

    // penable without setup phase is ignored.
    @(posedge clk);
    #1;
    psel = 1'b1; penable = 1'b1; paddr = 12'h010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("skip_setup_busy", 32'(busy), 32'h0);
    psel = 1'b0; penable = 1'b0;

    // Reset asserted in the ACCESS cycle of a read with N=2.
    @(posedge clk);
    #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h014; wait_cfg = 4'd2;
    pwdata = 32'h76543210; pstrb = 4'hF;
    @(posedge clk);
    #1;
    penable = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_ren", 32'(reg_ren), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0;

    apb_xfer(1'b1, 12'h00C, 32'h13572468, 4'h0, 4'd1, 32'h0, 1'b0, 1, 0, 32'h0);

    repeat (4) @(negedge clk);
    chk("queues_drained", 32'(strb_q.size() + resp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
